spi_led_ctrl: RTL and testbench

- Clock-domain controller that sequences the SPI command receive path into the LED outputs.
- Synchronizes sck/sdi/cs into clk and counts bits of each frame. Validates frame length and reserved bits, then applies the decoded pattern to LED.
- Framing: cs high = frame active, sdi MSB first, sampled on sck rising edge; cs falling = end of frame.
- Sits between the board SPI pins and the LED drive in the top level.

---
 rtl/spi_led_ctrl.sv | 166 ++++++++++++++++
 tb/tb_spi_led_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_led_ctrl.sv
// SPI command receiver: synchronizes sck/sdi/cs into clk, frames and validates commands, drives LED.
// Build option SPI_LED_HOLD_EN: LED keeps the last accepted pattern across shifts and rejected frames.
module spi_led_ctrl #(
    parameter int unsigned FRAME_BITS  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs,
    output logic [2:0]            LED,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            frame_cnt
);
    localparam int unsigned CNT_W  = $clog2(FRAME_BITS + 2);
    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]      CNT_OVR   = CNT_W'(FRAME_BITS + 1);
    localparam logic [WARM_W-1:0]     WARM_DONE = WARM_W'(SYNC_STAGES + 1);
    localparam logic [FRAME_BITS-1:0] RSV_MASK  =
        FRAME_BITS'((64'd1 << (FRAME_BITS - 3)) - 64'd1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DISPLAY} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
    logic                   sck_hist_q, cs_hist_q;
    logic [WARM_W-1:0]      warm_q;

    // Pin synchronizers plus history flops; warm_q masks the edges the cleared chain would fake after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_hist_q <= 1'b0;
            cs_hist_q  <= 1'b0;
            warm_q     <= '0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_hist_q <= sck_sync_q[SYNC_STAGES-1];
            cs_hist_q  <= cs_sync_q[SYNC_STAGES-1];
            if (warm_q != WARM_DONE) begin
                warm_q <= warm_q + WARM_W'(1);
            end
        end
    end

    logic sync_ok, sck_rise, cs_rise, cs_fall, sdi_s, accept;
    assign sync_ok  = (warm_q == WARM_DONE);
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sync_ok &  sck_sync_q[SYNC_STAGES-1] & ~sck_hist_q;
    assign cs_rise  = sync_ok &  cs_sync_q[SYNC_STAGES-1]  & ~cs_hist_q;
    assign cs_fall  = sync_ok & ~cs_sync_q[SYNC_STAGES-1]  &  cs_hist_q;

    state_e                state_q, state_d;
    logic [FRAME_BITS-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            led_q, led_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [7:0]            fcnt_q, fcnt_d;

    assign accept = (cnt_q == CNT_FULL) && ((sreg_q & RSV_MASK) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            rx_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            rx_q    <= rx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        rx_d    = rx_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (cs_rise) begin
                    state_d = SHIFT;
                    sreg_d  = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // A bit arriving with the cs fall is still captured before CHECK.
                if (sck_rise) begin
                    sreg_d = {sreg_q[FRAME_BITS-2:0], sdi_s};
                    if (cnt_q != CNT_OVR) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (cs_fall) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = DISPLAY;
                if (accept) begin
                    rx_d    = sreg_q;
                    led_d   = sreg_q[FRAME_BITS-1:FRAME_BITS-3];
                    valid_d = 1'b1;
                    fcnt_d  = fcnt_q + 8'd1;
                end else begin
                    err_d = 1'b1;
`ifdef SPI_LED_HOLD_EN
                    led_d = led_q;
`else
                    led_d = '0;
`endif
                end
            end
            DISPLAY: begin
                if (cs_rise) begin
                    state_d = SHIFT;
                    sreg_d  = '0;
                    cnt_d   = '0;
`ifdef SPI_LED_HOLD_EN
                    led_d   = led_q;
`else
                    led_d   = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SHIFT) || (state_d == CHECK);
    end

    assign LED         = led_q;
    assign rx_data     = rx_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_spi_led_ctrl.sv
// Self-checking bench for spi_led_ctrl: directed and random SPI frames against a frame-level model.
module tb_spi_led_ctrl;
    localparam int unsigned FB  = 8;
    localparam int unsigned SS  = 2;
    localparam int          LAT = SS + 2;
`ifdef SPI_LED_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          cs = 1'b0;
    logic [2:0]    LED;
    logic [FB-1:0] rx_data;
    logic          frame_valid, frame_err, busy;
    logic [7:0]    frame_cnt;

    int total = 0;
    int bad   = 0;

    // Frame-level reference state
    logic [2:0] exp_led;
    logic [7:0] exp_rx;
    logic [7:0] exp_cnt;

    spi_led_ctrl #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs),
        .LED(LED), .rx_data(rx_data), .frame_valid(frame_valid),
        .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic model_reset();
        exp_led = 3'b000;
        exp_rx  = 8'h00;
        exp_cnt = 8'h00;
    endtask

    // A frame is accepted only with exactly 8 bits and the low five bits clear.
    task automatic model_apply(input logic [15:0] bits, input int n, output bit acc);
        acc = (n == 8) && (bits[4:0] == 5'd0);
        if (acc) begin
            exp_rx  = bits[7:0];
            exp_led = bits[7:5];
            exp_cnt = exp_cnt + 8'd1;
        end else if (!HOLD) begin
            exp_led = 3'b000;
        end
    endtask

    task automatic clock_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            sdi = bits[n-1-i];
            repeat (2) @(negedge clk);
            sck = 1'b1;
            repeat (2) @(negedge clk);
            sck = 1'b0;
            @(negedge clk);
        end
    endtask

    // Drives one frame and records what the DUT shows; no judgement here.
    task automatic send_frame(input logic [15:0] bits, input int n,
                              output int nv, output int ne, output int lat,
                              output logic [2:0] led_mid, output logic busy_mid);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        clock_bits(bits, n);
        led_mid  = LED;
        busy_mid = busy;
        cs  = 1'b0;
        nv  = 0;
        ne  = 0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) nv++;
            if (frame_err) ne++;
            if ((frame_valid || frame_err) && lat < 0) lat = k;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cs = 1'b0; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        total++; if ({LED, rx_data, frame_valid, frame_err, busy, frame_cnt} !== '0) begin
            bad++; $display("FAIL reset_outputs: got LED=%b rx=%h v=%b e=%b busy=%b cnt=%0d expected all zero",
                            LED, rx_data, frame_valid, frame_err, busy, frame_cnt);
        end
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++; if ({LED, frame_valid, frame_err, busy, frame_cnt} !== '0) begin
            bad++; $display("FAIL reset_release_idle: got LED=%b v=%b e=%b busy=%b cnt=%0d expected all zero",
                            LED, frame_valid, frame_err, busy, frame_cnt);
        end
    endtask

    task automatic test_single_frame();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        send_frame(16'h0080, 8, nv, ne, lat, lm, bm);
        model_apply(16'h0080, 8, acc);
        total++; if (lm !== 3'b000) begin bad++; $display("FAIL single_led_during_shift: got %b expected 000", lm); end
        total++; if (bm !== 1'b1) begin bad++; $display("FAIL single_busy_shift: got %b expected 1", bm); end
        total++; if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL single_pulses: got v=%0d e=%0d expected v=1 e=0", nv, ne); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
        total++; if (LED !== 3'b100) begin bad++; $display("FAIL single_led: got %b expected 100", LED); end
        total++; if (rx_data !== 8'h80) begin bad++; $display("FAIL single_rx: got %h expected 80", rx_data); end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d expected 1", frame_cnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        send_frame(16'h0040, 8, nv, ne, lat, lm, bm);
        model_apply(16'h0040, 8, acc);
        total++; if (nv !== 1 || LED !== 3'b010) begin bad++; $display("FAIL b2b_first: got v=%0d LED=%b expected v=1 LED=010", nv, LED); end
        send_frame(16'h0020, 8, nv, ne, lat, lm, bm);
        total++; if (lm !== (HOLD ? 3'b010 : 3'b000)) begin
            bad++; $display("FAIL b2b_led_during_shift: got %b expected %b", lm, HOLD ? 3'b010 : 3'b000);
        end
        model_apply(16'h0020, 8, acc);
        total++; if (nv !== 1 || ne !== 0) begin bad++; $display("FAIL b2b_pulses: got v=%0d e=%0d expected v=1 e=0", nv, ne); end
        total++; if (LED !== 3'b001) begin bad++; $display("FAIL b2b_led: got %b expected 001", LED); end
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_short_frame();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        send_frame(16'h0010, 5, nv, ne, lat, lm, bm);
        model_apply(16'h0010, 5, acc);
        total++; if (nv !== 0 || ne !== 1) begin bad++; $display("FAIL short_pulses: got v=%0d e=%0d expected v=0 e=1", nv, ne); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL short_latency: got %0d expected %0d", lat, LAT); end
        total++; if (LED !== exp_led) begin bad++; $display("FAIL short_led: got %b expected %b", LED, exp_led); end
        total++; if (rx_data !== exp_rx) begin bad++; $display("FAIL short_rx: got %h expected %h", rx_data, exp_rx); end
        total++; if (frame_cnt !== exp_cnt) begin bad++; $display("FAIL short_cnt: got %0d expected %0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_bad_frames();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        send_frame(16'h0081, 8, nv, ne, lat, lm, bm);
        model_apply(16'h0081, 8, acc);
        total++; if (nv !== 0 || ne !== 1) begin bad++; $display("FAIL reserved_pulses: got v=%0d e=%0d expected v=0 e=1", nv, ne); end
        total++; if (rx_data !== exp_rx || frame_cnt !== exp_cnt) begin
            bad++; $display("FAIL reserved_state: got rx=%h cnt=%0d expected rx=%h cnt=%0d", rx_data, frame_cnt, exp_rx, exp_cnt);
        end
        send_frame(16'h0100, 9, nv, ne, lat, lm, bm);
        model_apply(16'h0100, 9, acc);
        total++; if (nv !== 0 || ne !== 1) begin bad++; $display("FAIL long_pulses: got v=%0d e=%0d expected v=0 e=1", nv, ne); end
        total++; if (LED !== exp_led || frame_cnt !== exp_cnt) begin
            bad++; $display("FAIL long_state: got LED=%b cnt=%0d expected LED=%b cnt=%0d", LED, frame_cnt, exp_led, exp_cnt);
        end
        send_frame(16'h0000, 8, nv, ne, lat, lm, bm);
        model_apply(16'h0000, 8, acc);
        total++; if (nv !== 1 || ne !== 0 || LED !== 3'b000 || rx_data !== 8'h00) begin
            bad++; $display("FAIL zero_frame: got v=%0d e=%0d LED=%b rx=%h expected v=1 e=0 LED=000 rx=00", nv, ne, LED, rx_data);
        end
    endtask

    task automatic test_reset_abort();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        int pulses;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        clock_bits(16'h000F, 4);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++; if ({LED, rx_data, busy, frame_cnt} !== '0) begin
            bad++; $display("FAIL abort_in_reset: got LED=%b rx=%h busy=%b cnt=%0d expected all zero", LED, rx_data, busy, frame_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clock_bits(16'h0000, 4);
        cs = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid || frame_err || busy) pulses++;
        end
        @(negedge clk);
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_pulses: got %0d active cycles expected 0", pulses); end
        send_frame(16'h0080, 8, nv, ne, lat, lm, bm);
        model_apply(16'h0080, 8, acc);
        total++; if (nv !== 1 || LED !== 3'b100 || frame_cnt !== 8'd1) begin
            bad++; $display("FAIL abort_next_frame: got v=%0d LED=%b cnt=%0d expected v=1 LED=100 cnt=1", nv, LED, frame_cnt);
        end
    endtask

    task automatic test_random();
        int nv, ne, lat; logic [2:0] lm, exp_mid; logic bm; bit acc;
        logic [15:0] d;
        int n;
        for (int f = 0; f < 30; f++) begin
            d = 16'($urandom);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 10)) : 8;
            if ($urandom_range(0, 1) == 1) d[4:0] = 5'd0;
            exp_mid = HOLD ? exp_led : 3'b000;
            send_frame(d, n, nv, ne, lat, lm, bm);
            model_apply(d, n, acc);
            total++; if (nv !== int'(acc) || ne !== int'(!acc)) begin
                bad++; $display("FAIL rand_pulses[%0d]: data=%h n=%0d got v=%0d e=%0d expected v=%0d e=%0d",
                                f, d, n, nv, ne, int'(acc), int'(!acc));
            end
            total++; if (lat !== LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", f, lat, LAT); end
            total++; if (lm !== exp_mid || bm !== 1'b1) begin
                bad++; $display("FAIL rand_shift[%0d]: got LED=%b busy=%b expected LED=%b busy=1", f, lm, bm, exp_mid);
            end
            total++; if (LED !== exp_led || rx_data !== exp_rx || frame_cnt !== exp_cnt) begin
                bad++; $display("FAIL rand_state[%0d]: got LED=%b rx=%h cnt=%0d expected LED=%b rx=%h cnt=%0d",
                                f, LED, rx_data, frame_cnt, exp_led, exp_rx, exp_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        int nv, ne, lat; logic [2:0] lm; logic bm; bit acc;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            send_frame(16'h0020, 8, nv, ne, lat, lm, bm);
            model_apply(16'h0020, 8, acc);
            total++; if (nv !== 1 || frame_cnt !== exp_cnt) begin
                bad++; $display("FAIL wrap_frame[%0d]: got v=%0d cnt=%0d expected v=1 cnt=%0d", f, nv, frame_cnt, exp_cnt);
            end
        end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt_zero: got %0d expected 0", frame_cnt); end
        total++; if (LED !== 3'b001) begin bad++; $display("FAIL wrap_led: got %b expected 001", LED); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_short_frame();
        test_bad_frames();
        test_reset_abort();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
